// File: rtl/axis_arb_pkg.sv
// Shared types and helpers for the round-robin AXI-Stream packet arbiter.
package axis_arb_pkg;

  // Two-state arbitration FSM: waiting for a request, or holding a grant for a packet.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_e;

  // Advance a round-robin pointer, wrapping n-1 back to 0.
  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/axis_rr_pkt_arbiter_rr_pick.sv
// Rotated priority encoder: first set request bit scanning ptr, ptr+1, ..., wrapping.
module rr_pick
  import axis_arb_pkg::*;
#(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [IDW-1:0] gnt_idx,
  output logic           any_req
);

  int unsigned    idx;
  logic [IDW-1:0] sel;
  logic           found;

  assign any_req = |req;

  // Walk the requests starting at ptr; the first hit wins.
  always_comb begin
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    sel     = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= N) begin
        idx = idx - N;
      end
      sel = IDW'(idx);
      if (!found && req[sel]) begin
        gnt_idx = sel;
        found   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axis_rr_pkt_arbiter.sv
// N-input AXI-Stream arbiter with round-robin grant held for a whole packet and a
// single registered output stage. The winning input index is reported on m_axis_tid.
module axis_rr_pkt_arbiter
  import axis_arb_pkg::*;
#(
  parameter int unsigned N   = 4,
  parameter int unsigned DW  = 32,
  parameter int unsigned IDW = $clog2(N)
) (
  input  logic            axis_aclk,
  input  logic            axis_aresetn,
  input  logic [N-1:0]    cfg_enable,
  input  logic [N*DW-1:0] s_axis_tdata,
  input  logic [N-1:0]    s_axis_tvalid,
  output logic [N-1:0]    s_axis_tready,
  input  logic [N-1:0]    s_axis_tlast,
  output logic [DW-1:0]   m_axis_tdata,
  output logic            m_axis_tvalid,
  input  logic            m_axis_tready,
  output logic            m_axis_tlast,
  output logic [IDW-1:0]  m_axis_tid,
  output logic            busy
);

  state_e         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] gnt_q, gnt_d;
  logic [IDW-1:0] pick_idx;
  logic           any_req;
  logic [N-1:0]   req;

  logic [DW-1:0]  tdata_q;
  logic           tvalid_q;
  logic           tlast_q;
  logic [IDW-1:0] tid_q;

  logic [DW-1:0]  sel_data;
  logic           sel_valid;
  logic           sel_last;
  logic           slot_ready;
  logic           accept;
  logic           pkt_end;

  // Disabled inputs never compete; an in-flight grant is unaffected by the mask.
  assign req = s_axis_tvalid & cfg_enable;

  rr_pick #(
    .N  (N),
    .IDW(IDW)
  ) u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .gnt_idx(pick_idx),
    .any_req(any_req)
  );

  assign sel_data   = s_axis_tdata[gnt_q*DW +: DW];
  assign sel_valid  = s_axis_tvalid[gnt_q];
  assign sel_last   = s_axis_tlast[gnt_q];
  // The output slot can take a beat if empty or draining this cycle.
  assign slot_ready = !tvalid_q || m_axis_tready;
  assign accept     = (state_q == ST_LOCK) && sel_valid && slot_ready;
  assign pkt_end    = accept && sel_last;

  // FSM state register.
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: lock on any enabled request, release after the tlast beat is taken.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (any_req) state_d = ST_LOCK;
      ST_LOCK: if (pkt_end) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: only the granted input sees ready, and only while locked.
  always_comb begin
    s_axis_tready = '0;
    busy          = 1'b0;
    if (state_q == ST_LOCK) begin
      busy                 = 1'b1;
      s_axis_tready[gnt_q] = slot_ready;
    end
  end

  // Grant captured at arbitration; pointer moves past the winner at packet end.
  always_comb begin
    gnt_d = gnt_q;
    ptr_d = ptr_q;
    if (state_q == ST_IDLE && any_req) begin
      gnt_d = pick_idx;
    end
    if (pkt_end) begin
      ptr_d = IDW'(rr_next(32'(gnt_q), N));
    end
  end

  // Grant and round-robin pointer registers.
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      gnt_q <= '0;
      ptr_q <= '0;
    end else begin
      gnt_q <= gnt_d;
      ptr_q <= ptr_d;
    end
  end

  // Output register: load on accept, otherwise empty out when the consumer takes it.
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tid_q    <= '0;
    end else if (accept) begin
      tdata_q  <= sel_data;
      tvalid_q <= 1'b1;
      tlast_q  <= sel_last;
      tid_q    <= gnt_q;
    end else if (m_axis_tready) begin
      tvalid_q <= 1'b0;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tid    = tid_q;

endmodule

// File: tb/tb_axis_rr_pkt_arbiter.sv
// Randomized bench for axis_rr_pkt_arbiter against a queue-based reference model.
module tb_axis_rr_pkt_arbiter;

  localparam int N   = 4;
  localparam int DW  = 32;
  localparam int IDW = 2;
  localparam int NCYC    = 4000;
  localparam int RST_CYC = 2000;

  logic            clk = 1'b0;
  logic            rstn;
  logic [N-1:0]    cfg_enable;
  logic [N*DW-1:0] s_tdata;
  logic [N-1:0]    s_tvalid;
  logic [N-1:0]    s_tready;
  logic [N-1:0]    s_tlast;
  logic [DW-1:0]   m_tdata;
  logic            m_tvalid;
  logic            m_tready;
  logic            m_tlast;
  logic [IDW-1:0]  m_tid;
  logic            busy;

  always #5 clk = ~clk;

  axis_rr_pkt_arbiter #(.N(N), .DW(DW), .IDW(IDW)) dut (
    .axis_aclk    (clk),
    .axis_aresetn (rstn),
    .cfg_enable   (cfg_enable),
    .s_axis_tdata (s_tdata),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready),
    .s_axis_tlast (s_tlast),
    .m_axis_tdata (m_tdata),
    .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready),
    .m_axis_tlast (m_tlast),
    .m_axis_tid   (m_tid),
    .busy         (busy)
  );

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: who holds the grant, the rr pointer, and what sits in the output slot.
  typedef struct {
    logic [DW-1:0] d;
    logic          l;
    int            id;
  } beat_t;

  beat_t out_q[$];
  bit    m_locked;
  int    m_gnt;
  int    m_ptr;
  bit    acc;
  int    acc_idx;
  int    grants[$];

  // Source state: AXIS producers holding each beat until it is taken.
  bit            src_valid[N];
  logic [DW-1:0] src_data[N];
  bit            src_last[N];
  int            beats_left[N];
  int            seq;

  task automatic model_reset();
    out_q.delete();
    m_locked = 0;
    m_gnt    = 0;
    m_ptr    = 0;
    acc      = 0;
    acc_idx  = 0;
    for (int i = 0; i < N; i++) begin
      src_valid[i]  = 0;
      src_data[i]   = '0;
      src_last[i]   = 0;
      beats_left[i] = 0;
    end
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      s_tvalid[i]          = src_valid[i];
      s_tlast[i]           = src_last[i];
      s_tdata[i*DW +: DW]  = src_data[i];
    end
  endtask

  task automatic check_outputs();
    logic [N-1:0] exp_rdy;
    exp_rdy = '0;
    if (m_locked) exp_rdy[m_gnt] = (out_q.size() == 0) || m_tready;
    check_eq("s_tready", 64'(s_tready), 64'(exp_rdy));
    check_eq("busy", 64'(busy), 64'(m_locked));
    check_eq("m_tvalid", 64'(m_tvalid), 64'(out_q.size() != 0));
    if (out_q.size() != 0) begin
      check_eq("m_tdata", 64'(m_tdata), 64'(out_q[0].d));
      check_eq("m_tlast", 64'(m_tlast), 64'(out_q[0].l));
      check_eq("m_tid", 64'(m_tid), 64'(out_q[0].id));
    end
  endtask

  // One clock of spec behaviour, using the inputs that will be sampled at the next edge.
  task automatic model_step();
    bit rdy;
    int k;
    rdy     = m_locked && ((out_q.size() == 0) || m_tready);
    acc     = rdy && src_valid[m_gnt];
    acc_idx = m_gnt;
    if (out_q.size() != 0 && m_tready) void'(out_q.pop_front());
    if (acc) out_q.push_back('{d: src_data[m_gnt], l: src_last[m_gnt], id: m_gnt});
    if (!m_locked) begin
      for (k = 0; k < N; k++) begin
        if (src_valid[(m_ptr + k) % N] && cfg_enable[(m_ptr + k) % N]) begin
          m_gnt    = (m_ptr + k) % N;
          m_locked = 1;
          grants.push_back(m_gnt);
          break;
        end
      end
    end else if (acc && src_last[m_gnt]) begin
      m_locked = 0;
      m_ptr    = (m_gnt + 1) % N;
    end
  endtask

  task automatic update_sources();
    if (acc) begin
      beats_left[acc_idx]--;
      src_valid[acc_idx] = 0;
    end
    for (int i = 0; i < N; i++) begin
      if (!src_valid[i] && $urandom_range(0, 9) < 7) begin
        if (beats_left[i] == 0) beats_left[i] = $urandom_range(1, 4);
        src_data[i]  = {8'(i), 8'h5a, 16'(seq)};
        seq++;
        src_last[i]  = (beats_left[i] == 1);
        src_valid[i] = 1;
      end
    end
  endtask

  initial begin
    rstn       = 1'b0;
    cfg_enable = '0;
    s_tdata    = '0;
    s_tvalid   = '0;
    s_tlast    = '0;
    m_tready   = 1'b0;
    seq        = 0;
    model_reset();
    #1;
    check_eq("rst_tvalid", 64'(m_tvalid), 64'(0));
    check_eq("rst_tready", 64'(s_tready), 64'(0));
    check_eq("rst_busy", 64'(busy), 64'(0));
    check_eq("rst_tdata", 64'(m_tdata), 64'(0));
    check_eq("rst_tid", 64'(m_tid), 64'(0));
    check_eq("rst_tlast", 64'(m_tlast), 64'(0));
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    cfg_enable = '1;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      if (cyc == RST_CYC + 1) rstn = 1'b1;
      check_outputs();
      if (cyc == RST_CYC) begin
        // Async reset mid-traffic: outputs must drop before any clock edge.
        rstn = 1'b0;
        #1;
        check_eq("midrst_tvalid", 64'(m_tvalid), 64'(0));
        check_eq("midrst_tready", 64'(s_tready), 64'(0));
        check_eq("midrst_busy", 64'(busy), 64'(0));
        check_eq("midrst_tdata", 64'(m_tdata), 64'(0));
        model_reset();
        drive_inputs();
        continue;
      end
      update_sources();
      // Long stretches of full throughput and of heavy backpressure.
      if ((cyc / 300) % 3 == 0) m_tready = 1'b1;
      else if ((cyc / 300) % 3 == 1) m_tready = ($urandom_range(0, 3) != 0);
      else m_tready = ($urandom_range(0, 3) == 0);
      if (cyc % 37 == 0) begin
        if ((cyc / 37) % 4 == 0) cfg_enable = '1;
        else if ((cyc / 37) % 9 == 0) cfg_enable = '0;
        else cfg_enable = N'($urandom_range(0, 15));
      end
      drive_inputs();
      model_step();
    end

    check_eq("grant_count_nonzero", 64'(grants.size() > 20), 64'(1));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
